// File: rtl/des_pkg.sv
// des_pkg -- shared constants and helpers for the DES key schedule.
//   PC1_TABLE / PC2_TABLE : FIPS 46-3 permuted-choice tables (1-based FIPS bits)
//   SHIFT_SCHED           : per-round left-shift amounts, index 0 = round 1
//   stateT, IDLE, RUN     : key-schedule FSM encoding
//   pc1(), rotl(), rotr() : permutation and 28-bit half rotations
// Bit convention: vector bit [W-1] holds FIPS bit 1.
package des_pkg;

    typedef logic [0:0] stateT;
    localparam stateT IDLE = 1'b0;
    localparam stateT RUN  = 1'b1;

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // 64-bit key (with parity) -> 56-bit C||D; parity bits are dropped here.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1_TABLE[i]];
        end
        return cd;
    endfunction

    // Rotate C and D independently left by 1 or 2.
    function automatic logic [55:0] rotl(input logic [55:0] cd, input logic [1:0] n);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        case (n)
            2'd1:    return {c[26:0], c[27], d[26:0], d[27]};
            2'd2:    return {c[25:0], c[27:26], d[25:0], d[27:26]};
            default: return cd;
        endcase
    endfunction

    // Rotate C and D independently right by 1 or 2.
    function automatic logic [55:0] rotr(input logic [55:0] cd, input logic [1:0] n);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        case (n)
            2'd1:    return {c[0], c[27:1], d[0], d[27:1]};
            2'd2:    return {c[1:0], c[27:2], d[1:0], d[27:2]};
            default: return cd;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2 -- combinational permuted choice 2.
//   cd     : 56-bit C||D register value (bit 55 = FIPS bit 1)
//   subKey : 48-bit round subkey (bit 47 = FIPS bit 1)
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subKey
);

    always_comb begin
        subKey = '0;
        for (int j = 0; j < 48; j++) begin
            subKey[47-j] = cd[56-PC2_TABLE[j]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// des_key_schedule -- streams DES round subkeys for one key per sequence.
//   clk, rst         : clock, asynchronous active-high reset
//   keyIn/keyValid/keyReady : 64-bit key (bit 63 = FIPS bit 1) handshake;
//                      decrypt is sampled with the key (1 = K16..K1 order)
//   subKey/subKeyValid/subKeyReady : 48-bit subkey stream handshake
//   roundIdx         : DES round of subKey (16 encoded as 0), 0 when idle
//   lastRound        : marks the ROUNDS-th subkey of the sequence
//   parityErr        : only with DES_KEY_PARITY_CHECK_EN defined; set when a
//                      byte of the accepted key has even parity
// Parameter ROUNDS (1..16) sets the number of subkeys per key.
module des_key_schedule
    import des_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] keyIn,
    input  logic        keyValid,
    output logic        keyReady,
    input  logic        decrypt,
    output logic [47:0] subKey,
    output logic        subKeyValid,
    input  logic        subKeyReady,
    output logic [3:0]  roundIdx,
    output logic        lastRound
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    output logic        parityErr
`endif
);

    localparam logic [4:0] LAST_COUNT = 5'(ROUNDS - 1);

    stateT       state;
    logic [55:0] cd;
    logic [4:0]  count;
    logic        decMode;

    logic        accept;
    logic        advance;
    logic        isLast;
    logic [3:0]  curRound;
    logic [3:0]  shiftIdx;
    logic [55:0] cdNext;

    assign keyReady    = (state == IDLE);
    assign subKeyValid = (state == RUN);
    assign accept      = keyValid && keyReady;
    assign advance     = subKeyValid && subKeyReady;
    assign isLast      = (count == LAST_COUNT);

    // 4-bit arithmetic wraps round 16 onto 4'h0, which is the output encoding.
    assign curRound = decMode ? (4'd0 - count[3:0]) : (count[3:0] + 4'd1);

    // Encrypt advances to the next round using its shift; decrypt undoes the
    // shift of the round just emitted. Index 16 (after K16) is never used.
    assign shiftIdx = decMode ? (4'd15 - count[3:0]) : (count[3:0] + 4'd1);
    assign cdNext   = decMode ? rotr(cd, SHIFT_SCHED[shiftIdx])
                              : rotl(cd, SHIFT_SCHED[shiftIdx]);

    assign roundIdx  = subKeyValid ? curRound : 4'd0;
    assign lastRound = subKeyValid && isLast;

    des_pc2 uPc2 (
        .cd     (cd),
        .subKey (subKey)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cd      <= '0;
            count   <= '0;
            decMode <= 1'b0;
        end else if (accept) begin
            // Encrypt preloads C1D1; decrypt starts from C0D0 == C16D16.
            state   <= RUN;
            decMode <= decrypt;
            count   <= '0;
            cd      <= decrypt ? pc1(keyIn) : rotl(pc1(keyIn), SHIFT_SCHED[0]);
        end else if (advance) begin
            cd    <= cdNext;
            count <= count + 5'd1;
            if (isLast) begin
                state <= IDLE;
            end
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic evenByte;

    always_comb begin
        evenByte = 1'b0;
        for (int b = 0; b < 8; b++) begin
            evenByte = evenByte | (~^keyIn[8*b +: 8]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parityErr <= 1'b0;
        end else if (accept) begin
            parityErr <= evenByte;
        end
    end
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule -- directed, scoreboard-based bench for des_key_schedule.
// Two instances: ROUNDS=16 (main) and ROUNDS=4 (short sequence).
// Build with DES_KEY_PARITY_CHECK_EN defined to include the parity checks.
module tb_des_key_schedule;

    localparam logic [63:0] KEY_OK  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

    // Reference subkeys K1..K16 for KEY_OK (textbook worked example).
    localparam logic [47:0] KTAB [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        last;
    } expT;

    expT sbq[$];
    int  checks = 0;
    int  errors = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] keyIn = '0;
    logic        keyValid = 1'b0;
    logic        keyReady;
    logic        decrypt = 1'b0;
    logic [47:0] subKey;
    logic        subKeyValid;
    logic        subKeyReady = 1'b0;
    logic [3:0]  roundIdx;
    logic        lastRound;

    logic [63:0] keyIn4 = '0;
    logic        keyValid4 = 1'b0;
    logic        keyReady4;
    logic        decrypt4 = 1'b0;
    logic [47:0] subKey4;
    logic        subKeyValid4;
    logic        subKeyReady4 = 1'b0;
    logic [3:0]  roundIdx4;
    logic        lastRound4;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic parityErr;
    logic parityErr4;
`endif

    always #5 clk = ~clk;

    des_key_schedule #(.ROUNDS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .keyIn       (keyIn),
        .keyValid    (keyValid),
        .keyReady    (keyReady),
        .decrypt     (decrypt),
        .subKey      (subKey),
        .subKeyValid (subKeyValid),
        .subKeyReady (subKeyReady),
        .roundIdx    (roundIdx),
        .lastRound   (lastRound)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .parityErr   (parityErr)
`endif
    );

    des_key_schedule #(.ROUNDS(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .keyIn       (keyIn4),
        .keyValid    (keyValid4),
        .keyReady    (keyReady4),
        .decrypt     (decrypt4),
        .subKey      (subKey4),
        .subKeyValid (subKeyValid4),
        .subKeyReady (subKeyReady4),
        .roundIdx    (roundIdx4),
        .lastRound   (lastRound4)
`ifdef DES_KEY_PARITY_CHECK_EN
        ,
        .parityErr   (parityErr4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pushSeq(input logic dec, input int n);
        expT e;
        int  r;
        for (int i = 0; i < n; i++) begin
            r      = dec ? (16 - i) : (i + 1);
            e.key  = KTAB[r-1];
            e.idx  = 4'(r);
            e.last = (i == n - 1);
            sbq.push_back(e);
        end
    endtask

    // Waits for keyReady, presents one key for a single cycle, then scrambles
    // keyIn/decrypt so later sampling of them would be visible.
    task automatic sendKey(input logic [63:0] k, input logic dec);
        int cyc;
        cyc = 0;
        while (!keyReady && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("keyReady_before_accept", 64'(keyReady), 64'd1);
        keyIn    = k;
        decrypt  = dec;
        keyValid = 1'b1;
        @(negedge clk);
        keyValid = 1'b0;
        keyIn    = ~k;
        decrypt  = ~dec;
    endtask

    // Pops and compares one scoreboard entry per observed handshake.
    task automatic drain(input int nItems, input int maxCyc);
        int  cyc;
        expT e;
        cyc = 0;
        while (nItems > 0 && cyc < maxCyc) begin
            if (subKeyValid && subKeyReady && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk($sformatf("subKey_r%0d", e.idx), 64'(subKey), 64'(e.key));
                chk($sformatf("roundIdx_r%0d", e.idx), 64'(roundIdx), 64'(e.idx));
                chk($sformatf("lastRound_r%0d", e.idx), 64'(lastRound), 64'(e.last));
                nItems--;
            end
            @(negedge clk);
            cyc++;
        end
        chk("drain_remaining", 64'(nItems), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int cyc;
        logic done;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_keyReady", 64'(keyReady), 64'd1);
        chk("rst_subKeyValid", 64'(subKeyValid), 64'd0);
        chk("rst_subKey", 64'(subKey), 64'd0);
        chk("rst_roundIdx", 64'(roundIdx), 64'd0);
        chk("rst_lastRound", 64'(lastRound), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("rst_parityErr", 64'(parityErr), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Encrypt, consumer always ready
        subKeyReady = 1'b1;
        pushSeq(1'b0, 16);
        sendKey(KEY_OK, 1'b0);
        chk("enc_keyReady_in_run", 64'(keyReady), 64'd0);
        drain(16, 100);
        chk("enc_keyReady_after", 64'(keyReady), 64'd1);
        chk("enc_subKeyValid_after", 64'(subKeyValid), 64'd0);
        chk("enc_roundIdx_after", 64'(roundIdx), 64'd0);

        // Decrypt
        pushSeq(1'b1, 16);
        sendKey(KEY_OK, 1'b1);
        drain(16, 100);
        chk("dec_keyReady_after", 64'(keyReady), 64'd1);

        // Backpressure at round 3
        pushSeq(1'b0, 16);
        sendKey(KEY_OK, 1'b0);
        drain(2, 20);
        subKeyReady = 1'b0;
        repeat (5) begin
            chk("stall_subKeyValid", 64'(subKeyValid), 64'd1);
            chk("stall_subKey", 64'(subKey), 64'(KTAB[2]));
            chk("stall_roundIdx", 64'(roundIdx), 64'd3);
            chk("stall_lastRound", 64'(lastRound), 64'd0);
            @(negedge clk);
        end
        subKeyReady = 1'b1;
        drain(14, 100);

        // Reset in the middle of a sequence
        pushSeq(1'b0, 16);
        sendKey(KEY_OK, 1'b0);
        drain(5, 20);
        sbq.delete();
        rst = 1'b1;
        #1;
        chk("midrst_subKeyValid", 64'(subKeyValid), 64'd0);
        chk("midrst_keyReady", 64'(keyReady), 64'd1);
        chk("midrst_subKey", 64'(subKey), 64'd0);
        chk("midrst_roundIdx", 64'(roundIdx), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("postrst_subKeyValid", 64'(subKeyValid), 64'd0);
        chk("postrst_keyReady", 64'(keyReady), 64'd1);
        pushSeq(1'b0, 16);
        sendKey(KEY_OK, 1'b0);
        drain(16, 100);

        // Key with bad parity: subkeys unaffected
        pushSeq(1'b0, 16);
        sendKey(KEY_BAD, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("parityErr_bad", 64'(parityErr), 64'd1);
`endif
        drain(16, 100);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("parityErr_held", 64'(parityErr), 64'd1);
`endif
        pushSeq(1'b0, 16);
        sendKey(KEY_OK, 1'b0);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("parityErr_good", 64'(parityErr), 64'd0);
`endif
        drain(16, 100);

        // ROUNDS=4 instance; keyValid stays high with another key during RUN
        keyIn4       = KEY_OK;
        decrypt4     = 1'b0;
        subKeyReady4 = 1'b1;
        chk("r4_keyReady_before", 64'(keyReady4), 64'd1);
        keyValid4    = 1'b1;
        @(negedge clk);
        keyIn4 = 64'hFEDCBA9876543210;
        hs   = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 30) begin
            if (subKeyValid4 && subKeyReady4) begin
                if (hs < 16) begin
                    chk($sformatf("r4_subKey_%0d", hs + 1), 64'(subKey4), 64'(KTAB[hs]));
                end
                chk($sformatf("r4_roundIdx_%0d", hs + 1), 64'(roundIdx4), 64'(hs + 1));
                chk($sformatf("r4_lastRound_%0d", hs + 1), 64'(lastRound4), 64'(hs == 3));
                hs++;
                if (lastRound4 || hs >= 6) begin
                    keyValid4 = 1'b0;
                    done      = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        keyValid4 = 1'b0;
        chk("r4_handshakes", 64'(hs), 64'd4);
        chk("r4_keyReady_after", 64'(keyReady4), 64'd1);
        chk("r4_subKeyValid_after", 64'(subKeyValid4), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
        chk("r4_parityErr", 64'(parityErr4), 64'd0);
`endif
        repeat (3) @(negedge clk);
        chk("r4_stays_idle", 64'(subKeyValid4), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
